// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: shared state encodings and transfer size codes
package mem_req_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: drives one MEM-stage load/store onto an SRAM-like bus and returns its response
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid_i,
    input  logic [DATA_W/8-1:0] req_wen_i,
    input  logic [1:0]          req_size_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic                req_uncached_i,
    output logic                req_ready_o,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                bus_req_o,
    output logic                bus_wr_o,
    output logic [1:0]          bus_size_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic                bus_uncached_o,
    input  logic                bus_addr_ok_i,
    input  logic                bus_data_ok_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    state_e              state_q, state_d;
    logic                discard_q, discard_d;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                wr_q, uncached_q;
    logic [1:0]          size_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                accept, done, deliver;

    assign accept  = req_valid_i & req_ready_o & ~flush_i;
    // Completion covers both the split handshake and addr_ok/data_ok arriving together.
    assign done    = (state_q == ADDR & bus_addr_ok_i & bus_data_ok_i) | (state_q == DATA & bus_data_ok_i);
    // A flush seen in the completing cycle also kills the response.
    assign deliver = done & ~discard_q & ~flush_i;

    // State register and discard flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Next-state logic; data_ok without a prior or same-cycle addr_ok is ignored
    always_comb begin
        state_d   = state_q;
        discard_d = done ? 1'b0 : (state_q != IDLE) & (discard_q | flush_i);
        unique case (state_q)
            IDLE:    state_d = accept ? ADDR : IDLE;
            ADDR:    state_d = bus_addr_ok_i ? (bus_data_ok_i ? IDLE : DATA) : ADDR;
            DATA:    state_d = bus_data_ok_i ? IDLE : DATA;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        req_ready_o = state_q == IDLE;
        bus_req_o   = state_q == ADDR;
        stall_o     = (state_q != IDLE) | (req_valid_i & state_q == IDLE & ~flush_i);
    end

    // Bus request fields, latched on acceptance and held for the whole transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            wstrb_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            uncached_q <= 1'b0;
        end else if (accept) begin
            wr_q       <= |req_wen_i;
            size_q     <= req_size_i;
            wstrb_q    <= req_wen_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            uncached_q <= req_uncached_i;
        end
    end

    // Response pulse and sticky read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= deliver;
            if (deliver) resp_rdata_q <= wr_q ? '0 : bus_rdata_i;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign bus_wr_o       = wr_q;
    assign bus_size_o     = size_q;
    assign bus_wstrb_o    = wstrb_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign bus_uncached_o = uncached_q;

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Downstream neighbour of the address-translation stage.
- Takes one physical-address load/store request per transaction from the MEM stage and drives it onto the SRAM-like data bus (req/addr_ok/data_ok).
- Tracks the single outstanding transaction, stalls the pipeline until it completes, and returns read data.
- Supports exception flush: the bus transaction is completed cleanly and its response is discarded.

Parameters:
- ADDR_W, 32, width of physical address.
- DATA_W, 32, width of data bus; byte-enable width is DATA_W/8.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req_valid_i  input  1  MEM-stage request present
- req_wen_i  input  DATA_W/8  byte write enables; all-zero means read
- req_size_i  input  2  00 byte, 01 half, 10 word
- req_addr_i  input  ADDR_W  physical address from translation stage
- req_wdata_i  input  DATA_W  store data, already byte-lane aligned
- req_uncached_i  input  1  kseg1 / uncached attribute, passed to bus
- req_ready_o  output  1  request accepted this cycle
- flush_i  input  1  exception/eret flush of the MEM stage
- stall_o  output  1  pipeline stall request
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  DATA_W  load data; zero for stores
- bus_req_o  output  1  bus request
- bus_wr_o  output  1  1 = write
- bus_size_o  output  2  transfer size
- bus_wstrb_o  output  DATA_W/8  byte strobes
- bus_addr_o  output  ADDR_W  bus address
- bus_wdata_o  output  DATA_W  write data
- bus_uncached_o  output  1  uncached attribute
- bus_addr_ok_i  input  1  address phase accepted
- bus_data_ok_i  input  1  data phase done
- bus_rdata_i  input  DATA_W  read data, valid with data_ok

Behaviour:
- **Reset:** resetn low forces state IDLE and drives every output 0 except req_ready_o=1. It also clears the discard flag.
- **States:** IDLE, ADDR, DATA.
- **req_ready_o:** equals (state==IDLE), combinational.
- **stall_o:** equals (state!=IDLE) | (req_valid_i & state==IDLE & ~flush_i), combinational.
- **Accept:** a request is accepted when req_valid_i & req_ready_o & ~flush_i.
  - On acceptance, the request fields are latched into the bus_* registers.
  - bus_wr_o = |req_wen_i.
  - State goes to ADDR; bus_req_o rises the next cycle.
- **ADDR:**
  - bus_req_o=1; all bus_* outputs are held stable.
  - On bus_addr_ok_i, bus_req_o drops the next cycle and state goes to DATA.
  - If bus_data_ok_i is high in the same cycle as bus_addr_ok_i, the transaction completes immediately: go to IDLE.
- **DATA:**
  - bus_req_o=0.
  - On bus_data_ok_i, go to IDLE.
  - resp_valid_o=1 for exactly the next cycle, with resp_rdata_o = captured bus_rdata_i for reads and 0 for writes.
- **Latency:**
  - Accept in cycle N; bus_req_o high in N+1.
  - If addr_ok arrives in cycle N+1 and data_ok in N+2, resp_valid_o and stall_o low occur in cycle N+3.
- **resp_rdata_o:** holds its value until the next response.
- **Flush with state!=IDLE:** sets the discard flag.
  - bus_req_o is NOT withdrawn before addr_ok; the transaction runs to data_ok.
  - resp_valid_o is suppressed for that transaction.
  - The discard flag clears on return to IDLE.
- **Flush while IDLE:** the same-cycle request is not accepted.
- **Back-to-back:**
  - A new request can be accepted in the cycle resp_valid_o is high, because state is IDLE then.
  - There is no bus bubble beyond one cycle.
- **data_ok in IDLE or ADDR without addr_ok:** ignored; this is illegal slave behaviour and the checker flags it.
- **Mid-transaction reset:** immediate return to IDLE with no response. The bus slave shares the same reset.

Decomposition:
- Shared defines header:
  - state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - size codes (SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10).
- No sub-module needed.
- The bus_* output register set may be a small internal always block; do not split it into a separate file.

Test Plan:
- **Word read:** request addr 0x1FC0_0010, wen 0, addr_ok at N+1, data_ok at N+2 with rdata 0xDEAD_BEEF -> resp_valid_o at N+3, resp_rdata_o=0xDEAD_BEEF, stall_o high N..N+2.
- **Byte store:** addr 0x0000_0103, wen 4'b1000, wdata 0xAB00_0000 -> bus_wr_o=1, bus_wstrb_o=4'b1000, bus_size_o=00; response rdata 0.
- **Slow slave:** addr_ok withheld 5 cycles -> bus_req_o and all bus_* stay constant for 5 cycles, stall_o stays high.
- **Same-cycle handshake:** addr_ok and data_ok high together -> IDLE next cycle, single resp_valid_o pulse.
- **Flush in ADDR:** assert flush_i one cycle before addr_ok -> bus transaction completes, resp_valid_o never asserts, next request accepted normally.
- **Reset mid-DATA:** drop resetn while waiting for data_ok -> all outputs 0 and req_ready_o=1 immediately, no response after release.
